// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: state encodings,
// default 27 MHz timing constants and the counter width helper.
package button_event_pkg;

   typedef enum logic [2:0] {
      LOCK   = 3'd0,
      IDLE   = 3'd1,
      PRESS1 = 3'd2,
      LONG   = 3'd3,
      WAIT2  = 3'd4,
      PRESS2 = 3'd5
   } state_e;

   localparam int unsigned DEF_LONG_CYCLES   = 13500000;  // 500 ms
   localparam int unsigned DEF_REPEAT_CYCLES = 2700000;   // 100 ms
   localparam int unsigned DEF_DCLICK_CYCLES = 6750000;   // 250 ms

   // Width that holds count values up to the largest timeout minus one.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      int unsigned w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      w = $clog2(m);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Debounced button level in, event pulses and held level out.
interface button_event_decoder_if;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic click;
   logic double_click;
   logic long_press;
   logic repeat_pulse;
   logic held;

   modport master (
      output btn_level,
      input  press_pulse, release_pulse, click, double_click,
             long_press, repeat_pulse, held
   );

   modport slave (
      input  btn_level,
      output press_pulse, release_pulse, click, double_click,
             long_press, repeat_pulse, held
   );
endinterface

// File: rtl/btn_event_timer.sv
// Shared dwell counter: cleared on request, otherwise counts while run is high.
module btn_event_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   // Count register: clear has priority over increment.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (run) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns the debounced button level into registered one-cycle event pulses
// (press, release, click, double-click, long-press, auto-repeat) plus a held level.
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int unsigned DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   button_event_decoder_if.slave  bus
);

   localparam int unsigned CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES);
   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
   localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] count;
   logic          tmr_clear, tmr_run;
   logic          clear_d;
   logic          press_d, release_d, click_d, dbl_d, long_d, rep_d, held_d;
   logic          press_q, release_q, click_q, dbl_q, long_q, rep_q, held_q;

   btn_event_timer #(.WIDTH(CW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (tmr_clear),
      .run   (tmr_run),
      .count (count)
   );

   // Next state and event decode; release/press take priority over timeouts.
   always_comb begin
      state_d   = state_q;
      clear_d   = 1'b0;
      tmr_run   = 1'b0;
      press_d   = 1'b0;
      release_d = 1'b0;
      click_d   = 1'b0;
      dbl_d     = 1'b0;
      long_d    = 1'b0;
      rep_d     = 1'b0;
      case (state_q)
         LOCK: begin
            if (!bus.btn_level) state_d = IDLE;
         end
         IDLE: begin
            if (bus.btn_level) begin
               state_d = PRESS1;
               press_d = 1'b1;
            end
         end
         PRESS1: begin
            tmr_run = 1'b1;
            if (!bus.btn_level) begin
               state_d   = WAIT2;
               release_d = 1'b1;
            end else if (count == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
            end
         end
         LONG: begin
            tmr_run = 1'b1;
            if (!bus.btn_level) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else if (count == REPEAT_LAST) begin
               clear_d = 1'b1;
               rep_d   = 1'b1;
            end
         end
         WAIT2: begin
            tmr_run = 1'b1;
            if (bus.btn_level) begin
               state_d = PRESS2;
               press_d = 1'b1;
               dbl_d   = 1'b1;
            end else if (count == DCLICK_LAST) begin
               state_d = IDLE;
               click_d = 1'b1;
            end
         end
         PRESS2: begin
            if (!bus.btn_level) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end
         end
         default: state_d = LOCK;
      endcase
      tmr_clear = clear_d || (state_d != state_q);
      held_d    = (state_d == PRESS1) || (state_d == LONG) || (state_d == PRESS2);
   end

   // State and registered outputs; reset drops any event in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LOCK;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         dbl_q     <= 1'b0;
         long_q    <= 1'b0;
         rep_q     <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         click_q   <= click_d;
         dbl_q     <= dbl_d;
         long_q    <= long_d;
         rep_q     <= rep_d;
         held_q    <= held_d;
      end
   end

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.click         = click_q;
   assign bus.double_click  = dbl_q;
   assign bus.long_press    = long_q;
   assign bus.repeat_pulse  = rep_q;
   assign bus.held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with short timeouts
// (LONG=8, REPEAT=4, DCLICK=5). Expected events carry the edge number they appear on.
module tb_button_event_decoder;

   localparam logic [5:0] PR  = 6'b100000;
   localparam logic [5:0] REL = 6'b010000;
   localparam logic [5:0] CLK = 6'b001000;
   localparam logic [5:0] DBL = 6'b000100;
   localparam logic [5:0] LNG = 6'b000010;
   localparam logic [5:0] REP = 6'b000001;

   typedef struct {
      int         cyc;
      logic [5:0] ev;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   e;
   int   e2;
   int   dummy;
   exp_t q[$];

   button_event_decoder_if bus();

   button_event_decoder #(
      .LONG_CYCLES   (8),
      .REPEAT_CYCLES (4),
      .DCLICK_CYCLES (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Edge counter: value seen at a negedge is the index of the preceding posedge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [5:0] ev_now();
      return {bus.press_pulse, bus.release_pulse, bus.click,
              bus.double_click, bus.long_press, bus.repeat_pulse};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive the level at a negedge; returns the edge that will sample it.
   task automatic drive(input logic v, output int edge_no);
      bus.btn_level = v;
      edge_no = cyc + 1;
   endtask

   task automatic want(input int c, input logic [5:0] ev);
      exp_t x;
      x.cyc = c;
      x.ev  = ev;
      q.push_back(x);
   endtask

   task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
      end
   endtask

   initial begin
      bus.btn_level = 1'b0;

      // Monitor: every cycle that shows any pulse is matched against the queue head.
      fork
         forever begin
            logic [5:0] ev;
            exp_t       x;
            @(negedge clk);
            ev = ev_now();
            if (ev != 6'b0) begin
               total++;
               if (q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_event cyc=%0d got=%b exp=none", cyc, ev);
               end else begin
                  x = q.pop_front();
                  if (x.cyc != cyc || x.ev != ev) begin
                     bad++;
                     $display("FAIL event cyc=%0d got=%b exp=%b@cyc%0d", cyc, ev, x.ev, x.cyc);
                  end
               end
            end
         end
      join_none

      // Reset state
      tick(3);
      chk("reset_outputs", {bus.held, ev_now()}, 7'b0);
      rst = 1'b0;
      tick(3);
      chk("idle_held", {6'b0, bus.held}, 7'b0);

      // Single click
      drive(1'b1, e); want(e, PR);
      tick(2);
      chk("press1_held", {6'b0, bus.held}, 7'd1);
      tick(1);
      drive(1'b0, dummy); want(e + 3, REL); want(e + 8, CLK);
      tick(2);
      chk("wait2_held", {6'b0, bus.held}, 7'd0);
      tick(10);

      // Double click
      drive(1'b1, e); want(e, PR);
      tick(3);
      drive(1'b0, dummy); want(e + 3, REL);
      tick(2);
      drive(1'b1, dummy); want(e + 5, PR | DBL);
      tick(2);
      chk("press2_held", {6'b0, bus.held}, 7'd1);
      tick(1);
      drive(1'b0, dummy); want(e + 8, REL);
      tick(12);

      // Long hold 20 cycles; release coincides with the third repeat hit
      drive(1'b1, e);
      want(e, PR); want(e + 8, LNG); want(e + 12, REP); want(e + 16, REP); want(e + 20, REL);
      tick(10);
      chk("long_held", {6'b0, bus.held}, 7'd1);
      tick(10);
      drive(1'b0, dummy);
      tick(12);

      // Release on the exact long-hit edge
      drive(1'b1, e); want(e, PR);
      tick(8);
      drive(1'b0, dummy); want(e + 8, REL); want(e + 13, CLK);
      tick(12);

      // Second press on the exact WAIT2 timeout edge
      drive(1'b1, e); want(e, PR);
      tick(3);
      drive(1'b0, dummy); want(e + 3, REL);
      tick(5);
      drive(1'b1, dummy); want(e + 8, PR | DBL);
      tick(2);
      drive(1'b0, dummy); want(e + 10, REL);
      tick(12);

      // Reset while held in LONG, released with the button still down
      drive(1'b1, e); want(e, PR); want(e + 8, LNG);
      tick(10);
      rst = 1'b1;
      tick(2);
      chk("rst_in_long_outputs", {bus.held, ev_now()}, 7'b0);
      rst = 1'b0;
      tick(6);
      chk("lock_held", {6'b0, bus.held}, 7'd0);
      drive(1'b0, dummy);
      tick(2);
      chk("lock_exit_held", {6'b0, bus.held}, 7'd0);
      drive(1'b1, e2); want(e2, PR);
      tick(2);
      drive(1'b0, dummy); want(e2 + 2, REL); want(e2 + 7, CLK);
      tick(12);

      // Reset mid-WAIT2: the pending click is dropped
      drive(1'b1, e); want(e, PR);
      tick(3);
      drive(1'b0, dummy); want(e + 3, REL);
      tick(2);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(12);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL missing_events got=%0d_left exp=0_left next=%b@cyc%0d",
                  q.size(), q[0].ev, q[0].cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the button debouncer. Consumes its clean, clk-synchronous debounced level.
- Converts that level into single-cycle event pulses: press, release, click, double-click, long-press and auto-repeat.
- Feeds counters, menu and LED logic, which then run on the system clock. No logic clocks off button edges.
- One clock domain (27 MHz board oscillator). All outputs are registered.

Parameters:
- LONG_CYCLES, 13500000, hold time before long_press fires (500 ms at 27 MHz).
- REPEAT_CYCLES, 2700000, auto-repeat period after long_press (100 ms).
- DCLICK_CYCLES, 6750000, window after release in which a second press counts as a double-click (250 ms).
- All three must be >= 2. Internal counter width is clog2 of the largest of the three.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst  in  1  reset; synchronous, active-high.
- btn_level  in  1  debounced button, 1 = pressed, already synchronous to clk.
- press_pulse  out  1  one-cycle pulse on each accepted press.
- release_pulse  out  1  one-cycle pulse on each accepted release.
- click  out  1  one-cycle pulse: short press with no second press inside the window.
- double_click  out  1  one-cycle pulse on the second press inside the window.
- long_press  out  1  one-cycle pulse when a first press is held LONG_CYCLES.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES while still held after long_press.
- held  out  1  level: high in PRESS1, LONG and PRESS2.

Behaviour:
- **Reset.** Synchronous. At a clk edge with rst=1: state <= LOCK, counter <= 0, all outputs <= 0. Reset mid-operation aborts any event silently; no pulse is emitted for it.
- **Timer.** One counter, cleared on every state transition and incremented on every other cycle.
  - A timeout "hits" at the edge where counter == N-1.
  - The resulting pulse is therefore visible exactly N cycles after the pulse or transition that entered the state.
- **Latency.** A btn_level change sampled at edge k produces its output at edge k, visible in cycle k+1 (one-cycle latency).
- **States and transitions:**
  - LOCK: wait for btn_level=0, then go to IDLE with no pulse. This prevents a phantom press if the button is held through reset.
  - IDLE: btn=1 -> PRESS1, press_pulse.
  - PRESS1:
    - btn=0 -> WAIT2, release_pulse.
    - Timer hit LONG_CYCLES while btn=1 -> LONG, long_press.
  - LONG:
    - btn=0 -> IDLE, release_pulse; no click.
    - Timer hit REPEAT_CYCLES -> repeat_pulse, counter cleared, stay in LONG.
  - WAIT2:
    - btn=1 -> PRESS2, press_pulse and double_click in the same cycle.
    - Timer hit DCLICK_CYCLES -> IDLE, click.
  - PRESS2: btn=0 -> IDLE, release_pulse. No long-press or repeat from PRESS2; the counter is idle here.
- **Simultaneous events:**
  - PRESS1: release and long hit on the same edge -> release wins (WAIT2, no long_press).
  - LONG: release and repeat hit together -> release only.
  - WAIT2: press and timeout together -> press wins (double_click, no click).
- **Pulse rules.**
  - Each pulse output is high for exactly one cycle per event; none stretches across back-to-back cycles.
  - press_pulse and release_pulse strictly alternate after LOCK exits.
  - Every click and double_click is preceded by its corresponding release_pulse or press_pulse.
- **Unreachable encodings** return to LOCK on the next edge.

Decomposition:
- Shared package button_event_pkg:
  - 3-bit state encodings LOCK, IDLE, PRESS1, LONG, WAIT2, PRESS2.
  - Default cycle constants for 27 MHz.
  - Helper for counter width.
- Sub-module btn_event_timer:
  - Parameter WIDTH.
  - Inputs clear and run; output count.
  - Hit comparison against the selected limit is done in the parent.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, DCLICK_CYCLES=5):
- **Single click.** btn high 3 cycles then low -> press_pulse 1 cycle after rise; release_pulse 1 cycle after fall; click exactly 5 cycles after release_pulse; no other pulses.
- **Double click.** btn high 3, low 2, high 3, low -> double_click coincident with the second press_pulse; one release_pulse after the second fall; click never asserts.
- **Long hold.** btn high 20 cycles -> long_press 8 cycles after press_pulse; repeat_pulse 4 and 8 cycles after long_press; release_pulse on fall; no click.
- **Boundaries.**
  - Release on the exact long-hit edge -> release_pulse, no long_press.
  - Second press on the exact WAIT2 timeout edge -> double_click, no click.
- **Reset.**
  - rst while btn held in LONG, then rst deasserted with btn still high -> no pulses, held=0, until btn goes low then high; then press_pulse.
  - rst asserted mid-WAIT2 -> click is never emitted.
